// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, handshakes with instruction memory
// and writes fetched instructions (or bubbles) into the IF/ID register.
//
// state | meaning
// IDLE  | post-reset settle cycle, no request
// REQ   | request outstanding at pc, waiting for ImemRdy
// HOLD  | ID stalled; fetched packet parked in pkt_buf, no request
// DRAIN | squashed request still in flight; discard its data then jump to redir_pc
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BrTaken,
   input  logic [31:0] BrTarget,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemRdy,
   input  logic [31:0] ImemData,
   output logic [95:0] dataOut,
   output logic        E,
   output logic        RW,
   output logic [31:0] Pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] redir_pc, redir_pc_n;
   logic [95:0] pkt_buf, pkt_buf_n;
   logic [95:0] data_out, data_out_n;
   logic        e, e_n;
   logic [31:0] pc_inc;

   assign pc_inc = pc + 32'd4;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         redir_pc <= 32'd0;
         pkt_buf  <= 96'd0;
         data_out <= 96'd0;
         e        <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         redir_pc <= redir_pc_n;
         pkt_buf  <= pkt_buf_n;
         data_out <= data_out_n;
         e        <= e_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      redir_pc_n = redir_pc;
      pkt_buf_n  = pkt_buf;
      data_out_n = data_out;
      e_n        = 1'b0;
      unique case (state)
         IDLE: state_n = REQ;
         REQ: begin
            if (BrTaken) begin
               data_out_n = 96'd0;
               e_n        = 1'b1;
               if (ImemRdy) begin
                  pc_n = BrTarget;
               end else begin
                  redir_pc_n = BrTarget;
                  state_n    = DRAIN;
               end
            end else if (Flush) begin
               // Replay the same pc once the in-flight word (if any) is gone.
               data_out_n = 96'd0;
               e_n        = 1'b1;
               if (!ImemRdy) begin
                  redir_pc_n = pc;
                  state_n    = DRAIN;
               end
            end else if (ImemRdy) begin
               pc_n = pc_inc;
               if (Stall) begin
                  pkt_buf_n = {pc_inc, pc, ImemData};
                  state_n   = HOLD;
               end else begin
                  data_out_n = {pc_inc, pc, ImemData};
                  e_n        = 1'b1;
               end
            end
         end
         HOLD: begin
            if (BrTaken) begin
               pc_n       = BrTarget;
               pkt_buf_n  = 96'd0;
               data_out_n = 96'd0;
               e_n        = 1'b1;
               state_n    = REQ;
            end else if (Flush) begin
               pc_n       = pkt_buf[63:32];
               pkt_buf_n  = 96'd0;
               data_out_n = 96'd0;
               e_n        = 1'b1;
               state_n    = REQ;
            end else if (!Stall) begin
               data_out_n = pkt_buf;
               e_n        = 1'b1;
               state_n    = REQ;
            end
         end
         DRAIN: begin
            if (BrTaken) redir_pc_n = BrTarget;
            if (BrTaken || Flush) begin
               data_out_n = 96'd0;
               e_n        = 1'b1;
            end
            if (ImemRdy) begin
               pc_n    = BrTaken ? BrTarget : redir_pc;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign ImemReq  = (state == REQ) || (state == DRAIN);
   assign ImemAddr = pc;
   assign Pc       = pc;
   assign dataOut  = data_out;
   assign E        = e;
   assign RW       = e;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: cycle vector table for fetch/wait states,
// hand sequences for stall, redirect, flush, wrap and reset; packets via scoreboard.
module tb_if_fetch;

   logic        Clk = 1'b0;
   logic        Rst, Stall, Flush, BrTaken, ImemRdy;
   logic [31:0] BrTarget, ImemData;
   logic        ImemReq, E, RW;
   logic [31:0] ImemAddr, Pc;
   logic [95:0] dataOut;

   if_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .BrTaken(BrTaken),
      .BrTarget(BrTarget), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemRdy(ImemRdy), .ImemData(ImemData), .dataOut(dataOut),
      .E(E), .RW(RW), .Pc(Pc)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   logic [95:0] exp_q[$];

   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      logic [31:0] data;
      logic        push;
      logic [95:0] pkt;
      logic        req;
      logic [31:0] addr;
      logic        e;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(logic br, logic [31:0] tgt, logic rdy, logic [31:0] data,
                               logic push, logic [95:0] pkt, logic req,
                               logic [31:0] addr, logic e);
      vec_t v;
      v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data; v.push = push;
      v.pkt = pkt; v.req = req; v.addr = addr; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every emitted packet (E=1) must match the oldest expected packet.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (E === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_packet actual=%0h required=none", dataOut);
         end else begin
            chk("packet", dataOut, exp_q.pop_front());
         end
      end
   endtask

   task automatic redirect(input logic [31:0] tgt);
      BrTaken = 1'b1; BrTarget = tgt; ImemRdy = 1'b1;
      exp_q.push_back(96'd0);
      tick();
      BrTaken = 1'b0; ImemRdy = 1'b0;
      chk("redir_addr", ImemAddr, tgt);
   endtask

   initial begin
      Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0; ImemRdy = 1'b0;
      BrTarget = 32'd0; ImemData = 32'd0;

      tbl[0] = mk(0, 0, 1, 32'hAAAA0001, 0, 96'd0, 1, 32'h100, 0);
      tbl[1] = mk(0, 0, 1, 32'hAAAA0001, 1, {32'h104, 32'h100, 32'hAAAA0001}, 1, 32'h104, 1);
      tbl[2] = mk(0, 0, 1, 32'hAAAA0002, 1, {32'h108, 32'h104, 32'hAAAA0002}, 1, 32'h108, 1);
      tbl[3] = mk(0, 0, 0, 32'd0, 0, 96'd0, 1, 32'h108, 0);
      tbl[4] = mk(1, 32'h200, 1, 32'd0, 1, 96'd0, 1, 32'h200, 1);
      tbl[5] = mk(0, 0, 0, 32'd0, 0, 96'd0, 1, 32'h200, 0);
      tbl[6] = mk(0, 0, 0, 32'd0, 0, 96'd0, 1, 32'h200, 0);
      tbl[7] = mk(0, 0, 0, 32'd0, 0, 96'd0, 1, 32'h200, 0);
      tbl[8] = mk(0, 0, 1, 32'hBBBB0200, 1, {32'h204, 32'h200, 32'hBBBB0200}, 1, 32'h204, 1);
      tbl[9] = mk(0, 0, 0, 32'd0, 0, 96'd0, 1, 32'h204, 0);

      repeat (3) tick();
      chk("rst_dataout", dataOut, 96'd0);
      chk("rst_e", E, 1'b0);
      chk("rst_rw", RW, 1'b0);
      chk("rst_req", ImemReq, 1'b0);
      chk("rst_pc", Pc, 32'h100);
      Rst = 1'b0;

      // Row 0 covers the IDLE cycle; ImemReq rises after it.
      for (int i = 0; i < 10; i++) begin
         BrTaken = tbl[i].br; BrTarget = tbl[i].tgt;
         ImemRdy = tbl[i].rdy; ImemData = tbl[i].data;
         if (tbl[i].push) exp_q.push_back(tbl[i].pkt);
         tick();
         chk($sformatf("row%0d_req", i), ImemReq, tbl[i].req);
         chk($sformatf("row%0d_addr", i), ImemAddr, tbl[i].addr);
         chk($sformatf("row%0d_e", i), E, tbl[i].e);
         chk($sformatf("row%0d_rw", i), RW, tbl[i].e);
      end
      BrTaken = 1'b0; ImemRdy = 1'b0;

      // Stall for 4 cycles at the 0x300 fetch
      redirect(32'h300);
      ImemRdy = 1'b1; ImemData = 32'hCCCC0300; Stall = 1'b1;
      tick();
      ImemRdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hold%0d_req", i), ImemReq, 1'b0);
         chk($sformatf("hold%0d_e", i), E, 1'b0);
         if (i < 3) tick();
      end
      Stall = 1'b0;
      exp_q.push_back({32'h304, 32'h300, 32'hCCCC0300});
      tick();
      chk("release_e", E, 1'b1);
      chk("release_req", ImemReq, 1'b1);
      chk("release_addr", ImemAddr, 32'h304);

      // Redirect while the 0x400 fetch is waiting
      redirect(32'h400);
      BrTaken = 1'b1; BrTarget = 32'h800;
      exp_q.push_back(96'd0);
      tick();
      BrTaken = 1'b0;
      chk("drain_bubble_e", E, 1'b1);
      chk("drain_addr0", ImemAddr, 32'h400);
      tick();
      chk("drain_req", ImemReq, 1'b1);
      chk("drain_addr1", ImemAddr, 32'h400);
      chk("drain_e", E, 1'b0);
      ImemRdy = 1'b1; ImemData = 32'hDEAD0400;
      tick();
      ImemRdy = 1'b0;
      chk("drain_done_e", E, 1'b0);
      chk("drain_done_addr", ImemAddr, 32'h800);
      chk("drain_done_req", ImemReq, 1'b1);

      // Flush while holding 0x500
      redirect(32'h500);
      ImemRdy = 1'b1; ImemData = 32'hEEEE0500; Stall = 1'b1;
      tick();
      ImemRdy = 1'b0; Flush = 1'b1;
      exp_q.push_back(96'd0);
      tick();
      Flush = 1'b0; Stall = 1'b0;
      chk("flush_hold_e", E, 1'b1);
      chk("flush_hold_req", ImemReq, 1'b1);
      chk("flush_hold_addr", ImemAddr, 32'h500);
      ImemRdy = 1'b1; ImemData = 32'hEEEE0501;
      exp_q.push_back({32'h504, 32'h500, 32'hEEEE0501});
      tick();
      ImemRdy = 1'b0;
      chk("refetch_pc", Pc, 32'h504);

      // PC wrap
      redirect(32'hFFFF_FFFC);
      ImemRdy = 1'b1; ImemData = 32'h1234_5678;
      exp_q.push_back({32'h0, 32'hFFFF_FFFC, 32'h1234_5678});
      tick();
      ImemRdy = 1'b0;
      chk("wrap_pc", Pc, 32'h0);

      // Reset while draining
      Flush = 1'b1;
      exp_q.push_back(96'd0);
      tick();
      Flush = 1'b0;
      chk("pre_rst_req", ImemReq, 1'b1);
      Rst = 1'b1;
      tick();
      chk("mid_rst_dataout", dataOut, 96'd0);
      chk("mid_rst_e", E, 1'b0);
      chk("mid_rst_rw", RW, 1'b0);
      chk("mid_rst_req", ImemReq, 1'b0);
      chk("mid_rst_pc", Pc, 32'h100);
      Rst = 1'b0;
      tick();
      chk("post_rst_req", ImemReq, 1'b1);
      chk("post_rst_addr", ImemAddr, 32'h100);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end of the pipelined CPU. It is the writer side of the IF/ID pipeline register. It owns the program counter, runs a request/ready handshake with instruction memory, and packs each fetched instruction into the 96-bit IF/ID packet. It also drives the register's `E`/`RW` controls and honours stall, flush and branch redirects from later stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `Clk` in 1: single clock, all state updates on posedge.
- `Rst` in 1: synchronous, active-high reset.
- `Stall` in 1: ID stage cannot accept a new packet this cycle.
- `Flush` in 1: squash the current or buffered instruction and emit a bubble.
- `BrTaken` in 1: branch or jump resolved taken. Implies flush.
- `BrTarget` in 32: redirect address, sampled when `BrTaken`=1.
- `ImemReq` out 1: fetch request to instruction memory.
- `ImemAddr` out 32: fetch address. Stable while `ImemReq`=1 until accepted.
- `ImemRdy` in 1: memory returns `ImemData` this cycle. The request completes at this edge.
- `ImemData` in 32: instruction word, valid only when `ImemRdy`=1.
- `dataOut` out 96: IF/ID packet. [95:64]=PC+4, [63:32]=PC, [31:0]=instruction.
- `E` out 1: IF/ID enable. One-cycle pulse per packet or bubble.
- `RW` out 1: IF/ID mode. Equal to `E` (1 = pass packet through).
- `Pc` out 32: current fetch PC, for debug.

## Operation
- **State register**: IDLE, REQ, HOLD, DRAIN.
- **Combinational outputs**:
  - `ImemReq` = 1 in REQ and DRAIN, otherwise 0.
  - `ImemAddr` = `Pc`.
  - `RW` = `E`.
- **IDLE**: entered on reset. Moves unconditionally to REQ next cycle.
- **REQ**: the request is held until `ImemRdy`=1. Priority at each edge is redirect > flush > stall > normal.
  - `BrTaken`, `ImemRdy`=1: `Pc`←`BrTarget`, data discarded, bubble emitted, stay in REQ.
  - `BrTaken`, `ImemRdy`=0: `RedirPc`←`BrTarget`, bubble emitted, go to DRAIN. The in-flight request cannot be cancelled.
  - `Flush` without `BrTaken`: bubble emitted. If `ImemRdy`=1, data discarded and `Pc` unchanged (replay). If `ImemRdy`=0, `RedirPc`←`Pc`, go to DRAIN.
  - `ImemRdy`=1, `Stall`=1: `Buf`←{`Pc`+4, `Pc`, `ImemData`}, `Pc`←`Pc`+4, `E`←0, go to HOLD.
  - `ImemRdy`=1, `Stall`=0: `dataOut`←{`Pc`+4, `Pc`, `ImemData`}, `E`←1, `Pc`←`Pc`+4, stay in REQ.
  - `ImemRdy`=0: `E`←0, stay in REQ.
- **HOLD**: no request is issued.
  - `BrTaken`: `Pc`←`BrTarget`, `Buf` dropped, bubble, go to REQ.
  - `Flush` alone: `Pc`←`Buf`[63:32], `Buf` dropped, bubble, go to REQ.
  - `Stall`=0: `dataOut`←`Buf`, `E`←1, go to REQ.
  - Otherwise: `E`←0, stay in HOLD.
- **DRAIN**: request is held at the old `Pc`.
  - `BrTaken`: `RedirPc`←`BrTarget` (latest redirect wins).
  - On `ImemRdy`=1: data discarded, `Pc`←`RedirPc` (or `BrTarget` if `BrTaken` that cycle), go to REQ.
  - `E`←0 except on a `BrTaken`/`Flush` cycle, which emits a bubble.
- **Bubble**: `dataOut`←96'b0, `E`←1. Emitted even when `Stall`=1, because squash has priority over the ID hold.
- **Arithmetic**: `Pc`+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- **Reset**: `Rst` at any edge (mid-request or in HOLD) forces the reset state below. An outstanding memory request is abandoned.

## Timing
- **Reset values**:
  - `dataOut`=96'b0, `E`=0, `RW`=0.
  - `ImemReq`=0, `Pc`=`RESET_PC`.
  - state=IDLE, `Buf`=0, `RedirPc`=0.
- **First request**: first cycle after `Rst` deasserts is IDLE. `ImemReq`=1 from the second cycle.
- **Latency**: the packet is registered, so `dataOut`/`E` are valid one cycle after the `ImemRdy` edge.
- **Throughput**: with `ImemRdy` tied high and no stall, one packet per cycle.
- **Stall release**: the buffered packet appears one cycle after `Stall` falls. The next request starts the same cycle as that packet.
- **Redirect**: the first fetch at the target is issued the cycle after the redirect edge (REQ case), or the cycle after drain completion (DRAIN case).
- `E` is never high for two consecutive cycles carrying the same packet.

## Test plan
- **Reset and first fetches**: `RESET_PC`=0x100, `ImemRdy`=1, fetch returns 0xAAAA0001 then 0xAAAA0002. Expect `ImemReq` rising 2 cycles after reset release. `dataOut`={0x104,0x100,0xAAAA0001} then {0x108,0x104,0xAAAA0002}, with `E`=1 on consecutive cycles.
- **Wait states**: `ImemRdy` low for 3 cycles on address 0x200. Expect `ImemAddr` stable at 0x200 and `E`=0 throughout. One packet follows, then `Pc`=0x204.
- **Stall**: `Stall`=1 for 4 cycles at the fetch of 0x300. Expect `ImemReq`=0 while in HOLD and `E`=0. After release, `dataOut`={0x304,0x300,instr}, `E`=1, and the next request is at 0x304.
- **Redirect mid-request**: `BrTaken`=1 with target 0x800 while the 0x400 fetch is waiting. Expect a bubble (`dataOut`=0, `E`=1). The request at 0x400 is held until `ImemRdy`, its data is never emitted, then the next `ImemAddr`=0x800.
- **Flush in HOLD**: `Flush`=1 while holding 0x500 with `Stall`=1. Expect a bubble and a refetch at 0x500.
- **Wrap and reset mid-operation**: `Pc`=0xFFFFFFFC gives a packet with PC+4=0. Asserting `Rst` in DRAIN returns all outputs to reset values the next cycle.
